// File: rtl/delay_checker_if.sv
// ----------------------------------------------------------------------------
// delay_checker_if
// Bundles the control, data and result signals of delay_checker.
//
// Signal semantics (no valid/ready pair on this block): start and stop are
// single-cycle pulses sampled on the rising clock edge; d_sent and q_in are
// sampled on every rising edge; all result signals are registered and may be
// sampled at any time, with pass meaningful only while done=1.
//
// Signals:
//   start, stop       control pulses               (master -> slave)
//   d_sent            word driven into delay stage (master -> slave)
//   q_in              delay stage output           (master -> slave)
//   busy, done, pass  run status                   (slave  -> master)
//   err_flag          sticky first-mismatch flag   (slave  -> master)
//   chk_cnt, err_cnt  saturating counters          (slave  -> master)
//   first_err_exp/got capture of the first mismatch(slave  -> master)
// ----------------------------------------------------------------------------
interface delay_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] d_sent;
  logic [WIDTH-1:0] q_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic             err_flag;
  logic [CNT_W-1:0] chk_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] first_err_exp;
  logic [WIDTH-1:0] first_err_got;

  modport master (
    output start, stop, d_sent, q_in,
    input  busy, done, pass, err_flag, chk_cnt, err_cnt, first_err_exp, first_err_got
  );

  modport slave (
    input  start, stop, d_sent, q_in,
    output busy, done, pass, err_flag, chk_cnt, err_cnt, first_err_exp, first_err_got
  );
endinterface

// File: rtl/delay_checker.sv
// ----------------------------------------------------------------------------
// delay_checker
// Self-check stage for a LATENCY-register delay line. Every cycle it records
// the word sent into the delay line and compares the delay line output
// against the word sent LATENCY edges earlier. Counts checks and mismatches,
// captures the first mismatch and reports pass/fail once a run is stopped.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   bus          delay_checker_if slave modport (controls, data, results)
//   o_dbg_state  current FSM state (IDLE=0, FILL=1, CHECK=2, DONE=3)
// ----------------------------------------------------------------------------
module delay_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  delay_checker_if.slave        bus,
  output logic [1:0]            o_dbg_state
);

  localparam int FILL_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_hist [LATENCY];
  logic [FILL_W-1:0]  r_fill_cnt;
  logic [CNT_W-1:0]   r_chk_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   w_chk_nxt;
  logic [CNT_W-1:0]   w_err_nxt;
  logic               r_err_flag;
  logic               r_pass;
  logic [WIDTH-1:0]   r_first_exp;
  logic [WIDTH-1:0]   r_first_got;
  logic [WIDTH-1:0]   w_expected;
  logic               w_mismatch;
  logic               w_fill_last;

  assign w_expected  = r_hist[LATENCY-1];
  assign w_mismatch  = (bus.q_in != w_expected);
  assign w_fill_last = (r_fill_cnt == FILL_W'(LATENCY - 1));

  // History runs in every state so the expected word is already valid on the
  // first CHECK edge; FILL only exists to let a fresh run's data reach it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) r_hist[i] <= '0;
    end else begin
      r_hist[0] <= bus.d_sent;
      for (int i = 1; i < LATENCY; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // start is honoured from every state and takes priority over stop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_FILL;
      S_FILL: begin
        if (bus.start)        w_next = S_FILL;
        else if (bus.stop)    w_next = S_DONE;
        else if (w_fill_last) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (bus.start)        w_next = S_FILL;
        else if (bus.stop)    w_next = S_DONE;
      end
      S_DONE:  if (bus.start) w_next = S_FILL;
      default:                w_next = S_IDLE;
    endcase
  end

  // Counter values after this edge, saturating at all-ones.
  always_comb begin
    w_chk_nxt = r_chk_cnt;
    w_err_nxt = r_err_cnt;
    if (r_state == S_CHECK) begin
      if (r_chk_cnt != CNT_MAX) w_chk_nxt = r_chk_cnt + 1'b1;
      if (w_mismatch && (r_err_cnt != CNT_MAX)) w_err_nxt = r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_cnt  <= '0;
      r_chk_cnt   <= '0;
      r_err_cnt   <= '0;
      r_err_flag  <= 1'b0;
      r_pass      <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else if (bus.start) begin
      r_fill_cnt  <= '0;
      r_chk_cnt   <= '0;
      r_err_cnt   <= '0;
      r_err_flag  <= 1'b0;
      r_pass      <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else begin
      r_chk_cnt <= w_chk_nxt;
      r_err_cnt <= w_err_nxt;
      if (r_state == S_FILL) r_fill_cnt <= r_fill_cnt + 1'b1;
      if ((r_state == S_CHECK) && w_mismatch && !r_err_flag) begin
        r_err_flag  <= 1'b1;
        r_first_exp <= w_expected;
        r_first_got <= bus.q_in;
      end
      // The stop edge is still compared, so pass uses the post-edge counts.
      if ((w_next == S_DONE) && (r_state != S_DONE))
        r_pass <= (w_err_nxt == '0) && (w_chk_nxt != '0);
    end
  end

  assign bus.busy          = (r_state == S_FILL) || (r_state == S_CHECK);
  assign bus.done          = (r_state == S_DONE);
  assign bus.pass          = r_pass;
  assign bus.err_flag      = r_err_flag;
  assign bus.chk_cnt       = r_chk_cnt;
  assign bus.err_cnt       = r_err_cnt;
  assign bus.first_err_exp = r_first_exp;
  assign bus.first_err_got = r_first_got;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_delay_checker.sv
module tb_delay_checker;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] d_sent = '0;
  logic [3:0] q_in = '0;
  logic [1:0] dbg16;
  logic [1:0] dbg4;

  delay_checker_if #(.WIDTH(4), .CNT_W(16)) if16 ();
  delay_checker_if #(.WIDTH(4), .CNT_W(4))  if4 ();

  assign if16.start = start;  assign if4.start = start;
  assign if16.stop = stop;    assign if4.stop = stop;
  assign if16.d_sent = d_sent; assign if4.d_sent = d_sent;
  assign if16.q_in = q_in;    assign if4.q_in = q_in;

  delay_checker #(.WIDTH(4), .LATENCY(LAT), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .bus(if16), .o_dbg_state(dbg16));
  delay_checker #(.WIDTH(4), .LATENCY(LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4), .o_dbg_state(dbg4));

  // ---------------- behavioural model ----------------
  // exp_q holds the last LAT words sent; the front is the word sent LAT edges ago.
  logic [3:0] exp_q[$];
  int         edge_n = 0;
  int         m_start = 0;
  bit         m_active = 0, m_done = 0, m_pass = 0, m_flag = 0;
  int         m_chk16 = 0, m_err16 = 0, m_chk4 = 0, m_err4 = 0;
  logic [3:0] m_fexp = '0, m_fgot = '0;
  logic [3:0] m_exp;

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : maxv;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q = {};
      for (int i = 0; i < LAT; i++) exp_q.push_back(4'h0);
      edge_n = 0; m_start = 0;
      m_active = 0; m_done = 0; m_pass = 0; m_flag = 0;
      m_chk16 = 0; m_err16 = 0; m_chk4 = 0; m_err4 = 0;
      m_fexp = '0; m_fgot = '0;
    end else begin
      m_exp = exp_q.pop_front();
      if (start) begin
        m_active = 1; m_done = 0; m_pass = 0; m_flag = 0; m_start = edge_n;
        m_chk16 = 0; m_err16 = 0; m_chk4 = 0; m_err4 = 0;
        m_fexp = '0; m_fgot = '0;
      end else if (m_active) begin
        // The first LAT edges after start only refill the pipe.
        if (edge_n - m_start > LAT) begin
          m_chk16 = sat_inc(m_chk16, 65535);
          m_chk4  = sat_inc(m_chk4, 15);
          if (q_in != m_exp) begin
            m_err16 = sat_inc(m_err16, 65535);
            m_err4  = sat_inc(m_err4, 15);
            if (!m_flag) begin m_flag = 1; m_fexp = m_exp; m_fgot = q_in; end
          end
        end
        if (stop) begin
          m_active = 0; m_done = 1;
          m_pass = (m_err16 == 0) && (m_chk16 != 0);
        end
      end
      exp_q.push_back(d_sent);
      edge_n++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy16", 32'(if16.busy), 32'(m_active));
      chk("done16", 32'(if16.done), 32'(m_done));
      chk("pass16", 32'(if16.pass), 32'(m_pass));
      chk("flag16", 32'(if16.err_flag), 32'(m_flag));
      chk("chk16", 32'(if16.chk_cnt), 32'(m_chk16));
      chk("err16", 32'(if16.err_cnt), 32'(m_err16));
      chk("fexp16", 32'(if16.first_err_exp), 32'(m_fexp));
      chk("fgot16", 32'(if16.first_err_got), 32'(m_fgot));
      chk("busy4", 32'(if4.busy), 32'(m_active));
      chk("done4", 32'(if4.done), 32'(m_done));
      chk("pass4", 32'(if4.pass), 32'(m_pass));
      chk("flag4", 32'(if4.err_flag), 32'(m_flag));
      chk("chk4", 32'(if4.chk_cnt), 32'(m_chk4));
      chk("err4", 32'(if4.err_cnt), 32'(m_err4));
    end
  end

  // ---------------- driver ----------------
  bit         d_inc = 0;
  logic [3:0] d_ctr = '0;

  // qm: 0 correct delay, 1 one-cycle delay, 2 correct delay ^1, else random.
  task automatic tick(input logic st, input logic sp, input int qm);
    @(negedge clk);
    start = st;
    stop  = sp;
    if (d_inc) begin d_sent = d_ctr; d_ctr = d_ctr + 4'h1; end
    else d_sent = 4'($urandom_range(0, 15));
    case (qm)
      0: q_in = exp_q[0];
      1: q_in = exp_q[LAT-1];
      2: q_in = exp_q[0] ^ 4'h1;
      default: q_in = 4'($urandom_range(0, 15));
    endcase
    @(posedge clk);
    #2;
  endtask

  // Start, LAT fill cycles, then nchk checks with stop on the last one.
  // Data after the start edge counts 0,1,2... so check j expects j mod 16.
  task automatic run(input int nchk, input int qm, input int fault_k);
    d_inc = 0;
    tick(1'b1, 1'b0, qm);
    d_ctr = '0; d_inc = 1;
    for (int k = 1; k <= LAT + nchk; k++)
      tick(1'b0, (k == LAT + nchk), (k == fault_k) ? 2 : qm);
    d_inc = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(if16.busy), 0);
    chk({tag, "_done"}, 32'(if16.done), 0);
    chk({tag, "_pass"}, 32'(if16.pass), 0);
    chk({tag, "_flag"}, 32'(if16.err_flag), 0);
    chk({tag, "_chk"}, 32'(if16.chk_cnt), 0);
    chk({tag, "_err"}, 32'(if16.err_cnt), 0);
    chk({tag, "_fexp"}, 32'(if16.first_err_exp), 0);
    chk({tag, "_fgot"}, 32'(if16.first_err_got), 0);
    chk({tag, "_chk4"}, 32'(if4.chk_cnt), 0);
  endtask

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1)); stop = 1'($urandom_range(0, 1));
      d_sent = 4'($urandom_range(0, 15)); q_in = 4'($urandom_range(0, 15));
      @(posedge clk); #2;
      cmp_en = 1;
    end
    check_zero("reset");
    @(negedge clk);
    start = 0; stop = 0; rst = 1'b1;
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b1, 0);
    chk("idle_stop_ignored", 32'(if16.done), 0);

    // Clean run: 20 checks.
    run(20, 0, 0);
    chk("clean_chk", 32'(if16.chk_cnt), 20);
    chk("clean_err", 32'(if16.err_cnt), 0);
    chk("clean_pass", 32'(if16.pass), 1);
    chk("clean_done", 32'(if16.done), 1);
    tick(1'b0, 1'b1, 3);
    chk("done_hold_chk", 32'(if16.chk_cnt), 20);

    // Single fault where expected = 5 (check index 5 -> tick LAT+1+5).
    run(20, 0, LAT + 6);
    chk("fault_err", 32'(if16.err_cnt), 1);
    chk("fault_flag", 32'(if16.err_flag), 1);
    chk("fault_fexp", 32'(if16.first_err_exp), 5);
    chk("fault_fgot", 32'(if16.first_err_got), 4);
    chk("fault_pass", 32'(if16.pass), 0);

    // Wrong latency: one-cycle delay, 10 checks.
    run(10, 1, 0);
    chk("lat_err", 32'(if16.err_cnt), 10);
    chk("lat_chk", 32'(if16.chk_cnt), 10);
    chk("lat_fexp", 32'(if16.first_err_exp), 0);
    chk("lat_fgot", 32'(if16.first_err_got), 1);

    // Saturation on the 4-bit counter instance.
    run(20, 2, 0);
    chk("sat_chk4", 32'(if4.chk_cnt), 15);
    chk("sat_err4", 32'(if4.err_cnt), 15);
    chk("sat_flag4", 32'(if4.err_flag), 1);
    chk("sat_chk16", 32'(if16.chk_cnt), 20);

    // Restart during CHECK after 7 checks.
    tick(1'b1, 1'b0, 0);
    for (int k = 0; k < LAT + 7; k++) tick(1'b0, 1'b0, 0);
    chk("pre_restart_chk", 32'(if16.chk_cnt), 7);
    tick(1'b1, 1'b0, 0);
    chk("restart_chk", 32'(if16.chk_cnt), 0);
    chk("restart_busy", 32'(if16.busy), 1);
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    chk("restart_fill_chk", 32'(if16.chk_cnt), 0);
    tick(1'b0, 1'b0, 0);
    chk("restart_first_chk", 32'(if16.chk_cnt), 1);

    // start+stop together, then stop in FILL.
    tick(1'b1, 1'b1, 0);
    chk("startstop_busy", 32'(if16.busy), 1);
    chk("startstop_done", 32'(if16.done), 0);
    tick(1'b0, 1'b1, 0);
    chk("fillstop_done", 32'(if16.done), 1);
    chk("fillstop_pass", 32'(if16.pass), 0);
    chk("fillstop_chk", 32'(if16.chk_cnt), 0);

    // Async reset mid-CHECK with a mismatch already recorded.
    tick(1'b1, 1'b0, 0);
    for (int k = 0; k < LAT + 4; k++) tick(1'b0, 1'b0, 2);
    #1 rst = 1'b0;
    #1 check_zero("midrst");
    @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Randomized control and data.
    for (int i = 0; i < 600; i++)
      tick(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3)));
    tick(1'b0, 1'b1, 0);
    tick(1'b0, 1'b0, 0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
